// File: rtl/hilo_divu_unit.sv
// HI/LO producer for the execute stage: a sequential restoring divider for DIVU that
// writes the remainder to HI and the quotient to LO after WIDTH iterations.
module hilo_divu_unit #(
  parameter int          WIDTH = 32,
  parameter logic [5:0]  DIVU  = 6'b011011
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       Signal,
  input  logic [WIDTH-1:0] dataA,
  input  logic [WIDTH-1:0] dataB,
  output logic [WIDTH-1:0] HiOut,
  output logic [WIDTH-1:0] LoOut,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    DIV  = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t           state;
  state_t           state_next;

  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] divisor;
  logic [CW-1:0]    count;

  logic             start;
  logic             last_step;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] rem_step;
  logic [WIDTH-1:0] quo_step;

  // The partial remainder is always below the divisor, so its extra top bit is
  // zero between steps and only the shifted/trial values need WIDTH+1 bits.
  always_comb begin
    start     = (Signal == DIVU) && ((state == IDLE) || (state == DONE));
    last_step = (state == DIV) && (count == CW'(WIDTH - 1));
    shifted   = {rem, quo[WIDTH-1]};
    trial     = shifted - {1'b0, divisor};
    quo_step  = {quo[WIDTH-2:0], ~trial[WIDTH]};
    rem_step  = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = DIV;
      DIV:     if (last_step) state_next = DONE;
      DONE:    state_next = start ? DIV : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rem     <= '0;
      quo     <= '0;
      divisor <= '0;
      count   <= '0;
      HiOut   <= '0;
      LoOut   <= '0;
    end else if (start) begin
      quo     <= dataA;
      divisor <= dataB;
      rem     <= '0;
      count   <= '0;
    end else if (state == DIV) begin
      rem   <= rem_step;
      quo   <= quo_step;
      count <= count + 1'b1;
      if (last_step) begin
        HiOut <= rem_step;
        LoOut <= quo_step;
      end
    end
  end

  always_comb begin
    busy = (state == DIV);
    done = (state == DONE);
  end

endmodule
